// File: rtl/cordic_scheduler.sv
// Time-shares one iterative 8-bit CORDIC core among N_CH phase-accumulator
// channels. Ticks advance the enabled accumulators and mark them pending;
// pending channels are granted round-robin, one rotation per grant, and
// each result is latched into that channel's sin/cos registers.
module cordic_scheduler #(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sample_tick_i,
  input  logic [N_CH-1:0]         enable_i,
  input  logic [N_CH*PHASE_W-1:0] phase_inc_i,
  input  logic [N_CH*8-1:0]       amp_i,
  output logic                    cordic_strb_o,
  output logic [7:0]              cordic_X_o,
  output logic [7:0]              cordic_Y_o,
  output logic [7:0]              cordic_Z_o,
  input  logic                    cordic_strb_i,
  input  logic [7:0]              cordic_X_i,
  input  logic [7:0]              cordic_Y_i,
  output logic [N_CH*8-1:0]       sin_o,
  output logic [N_CH*8-1:0]       cos_o,
  output logic [N_CH-1:0]         sample_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int          GW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int          TW     = $clog2(TIMEOUT);
  localparam int unsigned NCH_U  = N_CH;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state, state_next;
  logic [PHASE_W-1:0]  acc [N_CH];
  logic [N_CH-1:0]     pending;
  logic [GW-1:0]       grant, last_grant, scan_grant, cand;
  logic                scan_hit;
  logic [7:0]          sel_amp, sel_z;
  logic [TW-1:0]       timer;
  logic                done_hit, timeout_hit;
  logic [N_CH-1:0]     clr_vec, deliver_vec, ovr_vec;

  // The rotation never uses a Y operand.
  assign cordic_Y_o = '0;

  // Round-robin search for the next pending channel after last_grant,
  // plus the operand mux for whichever channel that search picks.
  always_comb begin
    scan_hit   = 1'b0;
    scan_grant = '0;
    cand       = '0;
    sel_amp    = '0;
    sel_z      = '0;
    for (int unsigned i = 1; i <= NCH_U; i++) begin
      cand = GW'((32'(last_grant) + i) % NCH_U);
      if (!scan_hit && pending[cand]) begin
        scan_hit   = 1'b1;
        scan_grant = cand;
      end
    end
    for (int unsigned ch = 0; ch < NCH_U; ch++) begin
      if (GW'(ch) == scan_grant) begin
        sel_amp = amp_i[ch*8 +: 8];
        sel_z   = acc[ch][PHASE_W-1 -: 8];
      end
    end
  end

  // FSM next-state logic with completion and abort qualifiers.
  always_comb begin
    state_next  = state;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:  if (scan_hit) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (cordic_strb_i) begin
          done_hit   = 1'b1;
          state_next = S_IDLE;
        end else if (timer == TMAX) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-channel qualifiers: pending clear on issue, result delivery, overrun.
  always_comb begin
    clr_vec     = '0;
    deliver_vec = '0;
    ovr_vec     = '0;
    for (int unsigned ch = 0; ch < NCH_U; ch++) begin
      clr_vec[ch]     = (state == S_ISSUE) && (grant == GW'(ch));
      deliver_vec[ch] = done_hit && (grant == GW'(ch)) && enable_i[ch];
      // A tick landing on the channel being issued re-arms it without
      // counting as an overrun.
      ovr_vec[ch]     = sample_tick_i && enable_i[ch] && pending[ch] && !clr_vec[ch];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // Grant bookkeeping, registered operands/strobe, WAIT timer, timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant         <= '0;
      last_grant    <= GW'(N_CH - 1);
      timer         <= '0;
      cordic_strb_o <= 1'b0;
      busy_o        <= 1'b0;
      cordic_X_o    <= '0;
      cordic_Z_o    <= '0;
      timeout_o     <= 1'b0;
    end else begin
      cordic_strb_o <= (state_next == S_ISSUE);
      busy_o        <= (state_next != S_IDLE);
      if (state == S_IDLE && scan_hit) begin
        grant      <= scan_grant;
        cordic_X_o <= sel_amp;
        cordic_Z_o <= sel_z;
      end
      if (state == S_ISSUE) begin
        last_grant <= grant;
        timer      <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + 1'b1;
      end
      if (timeout_hit) timeout_o <= 1'b1;
    end
  end

  // Phase accumulators, pending flags, result latches and overrun flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned ch = 0; ch < NCH_U; ch++) acc[ch] <= '0;
      pending        <= '0;
      sin_o          <= '0;
      cos_o          <= '0;
      sample_valid_o <= '0;
      overrun_o      <= 1'b0;
    end else begin
      sample_valid_o <= deliver_vec;
      if (|ovr_vec) overrun_o <= 1'b1;
      for (int unsigned ch = 0; ch < NCH_U; ch++) begin
        if (deliver_vec[ch]) begin
          sin_o[ch*8 +: 8] <= cordic_Y_i;
          cos_o[ch*8 +: 8] <= cordic_X_i;
        end
        if (!enable_i[ch]) begin
          acc[ch]     <= '0;
          pending[ch] <= 1'b0;
        end else if (sample_tick_i) begin
          acc[ch]     <= acc[ch] + phase_inc_i[ch*PHASE_W +: PHASE_W];
          pending[ch] <= 1'b1;
        end else if (clr_vec[ch]) begin
          pending[ch] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler: the core is modelled inline by the
// tasks, which return the strobe a chosen number of cycles after launch.
module tb_cordic_scheduler;

  logic        clk;
  logic        rst_i;
  logic        sample_tick_i;
  logic [1:0]  enable_i;
  logic [31:0] phase_inc_i;
  logic [15:0] amp_i;
  logic        cordic_strb_o;
  logic [7:0]  cordic_X_o, cordic_Y_o, cordic_Z_o;
  logic        cordic_strb_i;
  logic [7:0]  cordic_X_i, cordic_Y_i;
  logic [15:0] sin_o, cos_o;
  logic [1:0]  sample_valid_o;
  logic        busy_o, overrun_o, timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_scheduler #(.N_CH(2), .PHASE_W(16), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_tick_i(sample_tick_i),
    .enable_i(enable_i), .phase_inc_i(phase_inc_i), .amp_i(amp_i),
    .cordic_strb_o(cordic_strb_o), .cordic_X_o(cordic_X_o),
    .cordic_Y_o(cordic_Y_o), .cordic_Z_o(cordic_Z_o),
    .cordic_strb_i(cordic_strb_i), .cordic_X_i(cordic_X_i),
    .cordic_Y_i(cordic_Y_i), .sin_o(sin_o), .cos_o(cos_o),
    .sample_valid_o(sample_valid_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
  endtask

  task automatic do_reset();
    sample_tick_i = 1'b0;
    cordic_strb_i = 1'b0;
    enable_i      = '0;
    rst_i         = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  // Core model: wait for a launch, then return the strobe lat cycles later.
  task automatic core_serve(input int lat, input logic [7:0] xr, input logic [7:0] yr,
                            output logic [7:0] z, output logic [7:0] x, output bit ok);
    ok = 1'b0;
    z  = '0;
    x  = '0;
    for (int k = 0; k < 40 && cordic_strb_o !== 1'b1; k++) step();
    if (cordic_strb_o === 1'b1) begin
      z = cordic_Z_o;
      x = cordic_X_o;
      repeat (lat) step();
      cordic_strb_i = 1'b1;
      cordic_X_i    = xr;
      cordic_Y_i    = yr;
      step();
      cordic_strb_i = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; sample_tick_i = 1'b0; cordic_strb_i = 1'b0;
    enable_i = '0; phase_inc_i = '0; amp_i = '0;
    cordic_X_i = '0; cordic_Y_i = '0;
    #3 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({cordic_strb_o, cordic_X_o, cordic_Y_o, cordic_Z_o, sin_o, cos_o,
         sample_valid_o, busy_o, overrun_o, timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: sin=%h cos=%h sv=%b busy=%b ov=%b to=%b strb=%b, expected all 0",
               sin_o, cos_o, sample_valid_o, busy_o, overrun_o, timeout_o, cordic_strb_o);
    end
    step(); step();
    rst_i = 1'b0;
    step();
    enable_i = 2'b01;
    cordic_strb_i = 1'b1; cordic_X_i = 8'h55; cordic_Y_i = 8'h66;
    step();
    cordic_strb_i = 1'b0;
    n_checks++;
    if (sample_valid_o !== 2'b00 || sin_o !== 16'h0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_strobe: sv=%b sin=%h busy=%b, expected 00 0000 0", sample_valid_o, sin_o, busy_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    enable_i = 2'b01; phase_inc_i = {16'h0, 16'h4000}; amp_i = {8'h00, 8'h40};
    pulse_tick();
    n_checks++;
    if (cordic_strb_o !== 1'b0) begin
      n_fail++; $display("FAIL single_early_strb: got %b expected 0", cordic_strb_o);
    end
    step();
    n_checks++;
    if (cordic_strb_o !== 1'b1 || cordic_Z_o !== 8'h40 || cordic_X_o !== 8'h40 ||
        cordic_Y_o !== 8'h00 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: strb=%b Z=%h X=%h Y=%h busy=%b, expected 1 40 40 00 1",
               cordic_strb_o, cordic_Z_o, cordic_X_o, cordic_Y_o, busy_o);
    end
    amp_i = {8'h00, 8'h7F}; phase_inc_i = {16'h0, 16'h1234};
    step();
    n_checks++;
    if (cordic_strb_o !== 1'b0 || cordic_X_o !== 8'h40) begin
      n_fail++;
      $display("FAIL single_hold: strb=%b X=%h, expected 0 40", cordic_strb_o, cordic_X_o);
    end
    repeat (8) step();
    cordic_strb_i = 1'b1; cordic_X_i = 8'h02; cordic_Y_i = 8'h4D;
    step();
    cordic_strb_i = 1'b0;
    n_checks++;
    if (sin_o[7:0] !== 8'h4D || cos_o[7:0] !== 8'h02 || sample_valid_o !== 2'b01) begin
      n_fail++;
      $display("FAIL single_result: sin=%h cos=%h sv=%b, expected 4d 02 01",
               sin_o[7:0], cos_o[7:0], sample_valid_o);
    end
    step();
    n_checks++;
    if (sample_valid_o !== 2'b00 || sin_o[7:0] !== 8'h4D || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: sv=%b sin=%h busy=%b, expected 00 4d 0",
               sample_valid_o, sin_o[7:0], busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] z, x;
    bit ok;
    do_reset();
    enable_i = 2'b11; phase_inc_i = {16'h2000, 16'h1000}; amp_i = {8'h22, 8'h11};
    pulse_tick();
    core_serve(9, 8'h01, 8'h31, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h10 || x !== 8'h11 || sample_valid_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first: ok=%b Z=%h X=%h sv=%b, expected 1 10 11 01", ok, z, x, sample_valid_o);
    end
    core_serve(9, 8'h02, 8'h52, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h20 || x !== 8'h22 || sample_valid_o !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_second: ok=%b Z=%h X=%h sv=%b, expected 1 20 22 10", ok, z, x, sample_valid_o);
    end
    n_checks++;
    if (sin_o !== 16'h5231 || cos_o !== 16'h0201) begin
      n_fail++;
      $display("FAIL rr_latched: sin=%h cos=%h, expected 5231 0201", sin_o, cos_o);
    end
    step(); step();
    pulse_tick();
    core_serve(9, 8'h03, 8'h33, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h20 || x !== 8'h11) begin
      n_fail++;
      $display("FAIL rr_restart_ch0: ok=%b Z=%h X=%h, expected 1 20 11", ok, z, x);
    end
    core_serve(9, 8'h04, 8'h44, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h40 || x !== 8'h22) begin
      n_fail++;
      $display("FAIL rr_then_ch1: ok=%b Z=%h X=%h, expected 1 40 22", ok, z, x);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] z, x;
    logic [7:0] exp_z [3];
    bit ok;
    exp_z = '{8'hC0, 8'h80, 8'h40};
    do_reset();
    enable_i = 2'b01; phase_inc_i = {16'h0, 16'hC000}; amp_i = {8'h00, 8'h40};
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      core_serve(9, 8'h00, 8'h10, z, x, ok);
      n_checks++;
      if (!ok || z !== exp_z[k]) begin
        n_fail++;
        $display("FAIL wrap_z%0d: ok=%b Z=%h, expected 1 %h", k, ok, z, exp_z[k]);
      end
    end
    n_checks++;
    if (overrun_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_flags: ov=%b to=%b, expected 0 0", overrun_o, timeout_o);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] z, x;
    bit ok;
    do_reset();
    enable_i = 2'b11; phase_inc_i = {16'h0300, 16'h0100}; amp_i = {8'h22, 8'h11};
    pulse_tick();
    step();
    n_checks++;
    if (cordic_strb_o !== 1'b1 || cordic_Z_o !== 8'h01 || cordic_X_o !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_issue: strb=%b Z=%h X=%h, expected 1 01 11", cordic_strb_o, cordic_Z_o, cordic_X_o);
    end
    repeat (3) step();
    n_checks++;
    if (overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL ovr_before: got %b expected 0", overrun_o);
    end
    pulse_tick();
    n_checks++;
    if (overrun_o !== 1'b1) begin
      n_fail++; $display("FAIL ovr_rise: got %b expected 1", overrun_o);
    end
    repeat (5) step();
    cordic_strb_i = 1'b1; cordic_X_i = 8'h0A; cordic_Y_i = 8'h0B;
    step();
    cordic_strb_i = 1'b0;
    n_checks++;
    if (sample_valid_o !== 2'b01 || sin_o[7:0] !== 8'h0B) begin
      n_fail++;
      $display("FAIL ovr_ch0_done: sv=%b sin=%h, expected 01 0b", sample_valid_o, sin_o[7:0]);
    end
    core_serve(9, 8'h0C, 8'h0D, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h06 || x !== 8'h22) begin
      n_fail++; $display("FAIL ovr_ch1: ok=%b Z=%h X=%h, expected 1 06 22", ok, z, x);
    end
    core_serve(9, 8'h0E, 8'h0F, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h02 || x !== 8'h11) begin
      n_fail++; $display("FAIL ovr_ch0_again: ok=%b Z=%h X=%h, expected 1 02 11", ok, z, x);
    end
    n_checks++;
    if (overrun_o !== 1'b1 || sin_o !== 16'h0D0F) begin
      n_fail++;
      $display("FAIL ovr_sticky: ov=%b sin=%h, expected 1 0d0f", overrun_o, sin_o);
    end
  endtask

  task automatic test_tick_in_issue();
    logic [7:0] z, x;
    bit ok;
    do_reset();
    enable_i = 2'b01; phase_inc_i = {16'h0, 16'h4000}; amp_i = {8'h00, 8'h40};
    pulse_tick();
    step();
    pulse_tick();
    n_checks++;
    if (overrun_o !== 1'b0) begin
      n_fail++; $display("FAIL issue_tick_ovr: got %b expected 0", overrun_o);
    end
    repeat (8) step();
    cordic_strb_i = 1'b1; cordic_X_i = 8'h01; cordic_Y_i = 8'h4D;
    step();
    cordic_strb_i = 1'b0;
    core_serve(9, 8'h02, 8'h03, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h80 || overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_tick_rearm: ok=%b Z=%h ov=%b, expected 1 80 0", ok, z, overrun_o);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] z, x;
    bit ok;
    bit sv_seen;
    do_reset();
    enable_i = 2'b01; phase_inc_i = {16'h0, 16'h4000}; amp_i = {8'h00, 8'h40};
    pulse_tick();
    step();
    sv_seen = 1'b0;
    repeat (15) begin
      step();
      sv_seen |= |sample_valid_o;
    end
    n_checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL to_before: to=%b busy=%b, expected 0 1", timeout_o, busy_o);
    end
    step();
    sv_seen |= |sample_valid_o;
    n_checks++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0 || sv_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL to_rise: to=%b busy=%b sv_seen=%b, expected 1 0 0", timeout_o, busy_o, sv_seen);
    end
    cordic_strb_i = 1'b1; cordic_X_i = 8'h76; cordic_Y_i = 8'h77;
    step();
    cordic_strb_i = 1'b0;
    step();
    n_checks++;
    if (sample_valid_o !== 2'b00 || sin_o !== 16'h0 || timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_idle_strobe: sv=%b sin=%h to=%b, expected 00 0000 1", sample_valid_o, sin_o, timeout_o);
    end
    // Latest acceptable strobe versus one cycle too late.
    do_reset();
    enable_i = 2'b01;
    pulse_tick();
    core_serve(15, 8'h01, 8'h3C, z, x, ok);
    n_checks++;
    if (!ok || sample_valid_o !== 2'b01 || sin_o[7:0] !== 8'h3C || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_edge_ok: ok=%b sv=%b sin=%h to=%b, expected 1 01 3c 0",
               ok, sample_valid_o, sin_o[7:0], timeout_o);
    end
    pulse_tick();
    core_serve(16, 8'h01, 8'h3D, z, x, ok);
    n_checks++;
    if (!ok || sample_valid_o !== 2'b00 || sin_o[7:0] !== 8'h3C || timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_edge_late: ok=%b sv=%b sin=%h to=%b, expected 1 00 3c 1",
               ok, sample_valid_o, sin_o[7:0], timeout_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] z, x;
    bit ok;
    do_reset();
    enable_i = 2'b01; phase_inc_i = {16'h0, 16'h4000}; amp_i = {8'h00, 8'h40};
    pulse_tick();
    core_serve(9, 8'h02, 8'h4D, z, x, ok);
    pulse_tick();
    step();
    repeat (3) step();
    n_checks++;
    if (busy_o !== 1'b1 || sin_o[7:0] !== 8'h4D || !ok) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b sin=%h ok=%b, expected 1 4d 1", busy_o, sin_o[7:0], ok);
    end
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({cordic_strb_o, cordic_X_o, cordic_Z_o, sin_o, cos_o, sample_valid_o,
         busy_o, overrun_o, timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: X=%h Z=%h sin=%h cos=%h busy=%b, expected all 0",
               cordic_X_o, cordic_Z_o, sin_o, cos_o, busy_o);
    end
    step();
    rst_i = 1'b0;
    step();
    cordic_strb_i = 1'b1; cordic_X_i = 8'h98; cordic_Y_i = 8'h99;
    step();
    cordic_strb_i = 1'b0;
    n_checks++;
    if (sample_valid_o !== 2'b00 || sin_o !== 16'h0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_late_strobe: sv=%b sin=%h busy=%b, expected 00 0000 0", sample_valid_o, sin_o, busy_o);
    end
  endtask

  task automatic test_disable();
    logic [7:0] z, x;
    bit ok;
    bit sv_seen;
    do_reset();
    enable_i = 2'b01; phase_inc_i = {16'h0, 16'h4000}; amp_i = {8'h00, 8'h40};
    pulse_tick();
    core_serve(9, 8'h02, 8'h4D, z, x, ok);
    pulse_tick();
    step();
    repeat (3) step();
    enable_i = 2'b00;
    sv_seen = 1'b0;
    repeat (6) begin
      step();
      sv_seen |= |sample_valid_o;
    end
    cordic_strb_i = 1'b1; cordic_X_i = 8'h98; cordic_Y_i = 8'h99;
    step();
    cordic_strb_i = 1'b0;
    sv_seen |= |sample_valid_o;
    step();
    sv_seen |= |sample_valid_o;
    n_checks++;
    if (sv_seen !== 1'b0 || sin_o[7:0] !== 8'h4D || cos_o[7:0] !== 8'h02 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_discard: sv_seen=%b sin=%h cos=%h busy=%b, expected 0 4d 02 0",
               sv_seen, sin_o[7:0], cos_o[7:0], busy_o);
    end
    enable_i = 2'b01;
    pulse_tick();
    core_serve(9, 8'h05, 8'h06, z, x, ok);
    n_checks++;
    if (!ok || z !== 8'h40) begin
      n_fail++; $display("FAIL dis_acc_cleared: ok=%b Z=%h, expected 1 40", ok, z);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_overrun();
    test_tick_in_issue();
    test_timeout();
    test_reset_mid_wait();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
